// File: rtl/eq2_seq_pkg.sv
// Shared definitions for the eq2 vector self-test sequencer:
// state encoding, vector field layout and vector width.
package eq2_seq_pkg;

    // One vector is {a[1:0], b[1:0], exp}
    localparam int VEC_W   = 5;
    localparam int A_MSB   = 4;
    localparam int A_LSB   = 3;
    localparam int B_MSB   = 2;
    localparam int B_LSB   = 1;
    localparam int EXP_BIT = 0;

    // State encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_SETTLE = ST_SETTLE,
        S_CHECK  = ST_CHECK,
        S_DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/eq2_vec_ram.sv
// Vector memory: 2^ADDR_W entries of VEC_W bits, synchronous write,
// asynchronous (combinational) read. Contents are never reset.
module eq2_vec_ram
    import eq2_seq_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [VEC_W-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [VEC_W-1:0]  o_rdata
);

    logic [VEC_W-1:0] r_mem [2**ADDR_W];

    // Write port: one entry per enabled rising edge
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/eq2_vec_seq.sv
// Self-test sequencer for the 2-bit equality comparator. Applies stored
// vectors to an external comparator, waits SETTLE cycles, samples aeqb and
// accumulates mismatches.
// Optional build macro EQ2_SEQ_STOP_ON_FAIL_EN: the first mismatch ends the
// run immediately (default build always runs all N_VEC vectors).
//
// Control protocol: start is a level sampled only in IDLE (ignored while
// busy, never queued); done is a one-cycle pulse marking the end of a run;
// pass/err_cnt/fail_* are valid from done until the next accepted start.
// wr_en writes only while busy=0; a write and start in the same cycle are
// both honoured and the run sees the new data.
module eq2_vec_seq
    import eq2_seq_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int N_VEC  = 8,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [VEC_W-1:0]  wr_data,
    input  logic              aeqb,
    output logic [1:0]        a,
    output logic [1:0]        b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_VEC - 1);
    localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(SETTLE - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_a;
    logic [1:0]          r_b;
    logic                r_exp;
    logic [ADDR_W:0]     r_err;
    logic                r_fail_valid;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic                r_pass;

    logic [VEC_W-1:0]    w_rdata;
    logic                w_mismatch;
    logic                w_stop;
    logic                w_last;
    logic [ADDR_W:0]     w_err_next;

    eq2_vec_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_we    (wr_en && (r_state == S_IDLE)),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

    assign w_mismatch = (aeqb != r_exp);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_err_next = r_err + {{ADDR_W{1'b0}}, w_mismatch};

`ifdef EQ2_SEQ_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_LOAD;
            S_LOAD:   w_next_state = S_SETTLE;
            S_SETTLE: if (r_cnt == '0) w_next_state = S_CHECK;
            S_CHECK:  w_next_state = (w_last || w_stop) ? S_DONE : S_LOAD;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand registers, settle counter, index and error tracking.
    // pass is captured on the CHECK->DONE edge so it is already valid while
    // done is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= '0;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_exp        <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_addr  <= '0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx        <= '0;
                        r_err        <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_addr  <= '0;
                        r_pass       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_a   <= w_rdata[A_MSB:A_LSB];
                    r_b   <= w_rdata[B_MSB:B_LSB];
                    r_exp <= w_rdata[EXP_BIT];
                    r_cnt <= CNT_START;
                end
                S_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_addr  <= r_idx;
                    end
                    if (w_last || w_stop) begin
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign a          = r_a;
    assign b          = r_b;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign pass       = r_pass;
    assign err_cnt    = r_err;
    assign fail_valid = r_fail_valid;
    assign fail_addr  = r_fail_addr;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_eq2_vec_seq.sv
// Bench for eq2_vec_seq: table of full runs scored through an expected
// queue, plus hand sequences for mid-run start/write, async reset abort and
// a minimal SETTLE=1/N_VEC=1 instance.
module tb_eq2_vec_seq;

`ifdef EQ2_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (defaults) ----------------
    logic       start = 0, wr_en = 0, stuck = 0;
    logic [2:0] wr_addr = 0;
    logic [4:0] wr_data = 0;
    logic       aeqb;
    logic [1:0] a, b;
    logic       busy, done, pass, fail_valid;
    logic [3:0] err_cnt;
    logic [2:0] fail_addr, dbg_state;

    assign aeqb = stuck ? 1'b0 : (a == b);

    eq2_vec_seq u_dut (
        .clk(clk), .reset(reset), .start(start), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .aeqb(aeqb),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_addr(fail_addr),
        .dbg_state(dbg_state)
    );

    // ---------------- small DUT (SETTLE=1, N_VEC=1) ----------------
    logic       s_start = 0, s_wr_en = 0;
    logic [2:0] s_wr_addr = 0;
    logic [4:0] s_wr_data = 0;
    logic       s_aeqb;
    logic [1:0] s_a, s_b;
    logic       s_busy, s_done, s_pass, s_fail_valid;
    logic [3:0] s_err_cnt;
    logic [2:0] s_fail_addr, s_dbg_state;

    assign s_aeqb = (s_a == s_b);

    eq2_vec_seq #(.ADDR_W(3), .N_VEC(1), .SETTLE(1)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .wr_en(s_wr_en),
        .wr_addr(s_wr_addr), .wr_data(s_wr_data), .aeqb(s_aeqb),
        .a(s_a), .b(s_b), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_cnt(s_err_cnt), .fail_valid(s_fail_valid), .fail_addr(s_fail_addr),
        .dbg_state(s_dbg_state)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] mk_res(input logic p, input logic [3:0] e,
                                          input logic fv, input logic [2:0] fa);
        return {p, e, fv, fa};
    endfunction

    // Scoreboard: one expected {pass, err_cnt, fail_valid, fail_addr} per run
    logic [8:0] exp_q[$];

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected: got done=1 with no run outstanding, required done=0");
            end else begin
                check("run_result", {pass, err_cnt, fail_valid, fail_addr}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Writes addresses 7..1, then address 0 in the same cycle as start.
    // Returns at the first negedge after the start edge (cycle T+1).
    task automatic load_and_start(input logic [39:0] vecs);
        for (int i = 7; i >= 1; i--) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = vecs[i*5 +: 5];
        end
        @(negedge clk);
        wr_addr = 3'd0;
        wr_data = vecs[4:0];
        start   = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    task automatic start_only();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; k counts cycles since the start edge.
    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_outputs"}, {a, b, busy, done, pass, err_cnt, fail_valid, fail_addr}, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- test table ----------------
    typedef struct {
        logic [39:0] vecs;
        logic        stuck;
        logic [8:0]  res;
        int          lat;
        int          last;
    } case_t;

    case_t tbl[5];

    logic [39:0] v_ok, v_b, v_s, v_d, v_e;
    int k;

    initial begin
        // {v7, ..., v0}; equal pairs at 0,2,4,6
        v_ok = {5'b11000, 5'b10101, 5'b00110, 5'b01011,
                5'b10010, 5'b11111, 5'b01100, 5'b00001};
        v_b = v_ok; v_b[19:15] = 5'b10011;              // vector 3 exp wrong
        v_s = {v_ok[39:10], 5'b00001, 5'b01100};        // first equal pair at 1
        v_d = v_ok; v_d[14:10] = 5'b11110; v_d[34:30] = 5'b10100;
        v_e = v_ok ^ {8{5'b00001}};                     // every exp wrong

        tbl[0] = '{v_ok, 1'b0, mk_res(1, 0, 0, 0), 33, 7};
        tbl[1] = '{v_b,  1'b0, STOP ? mk_res(0, 1, 1, 3) : mk_res(0, 1, 1, 3), STOP ? 17 : 33, STOP ? 3 : 7};
        tbl[2] = '{v_s,  1'b1, STOP ? mk_res(0, 1, 1, 1) : mk_res(0, 4, 1, 1), STOP ? 9  : 33, STOP ? 1 : 7};
        tbl[3] = '{v_d,  1'b0, STOP ? mk_res(0, 1, 1, 2) : mk_res(0, 2, 1, 2), STOP ? 13 : 33, STOP ? 2 : 7};
        tbl[4] = '{v_e,  1'b0, STOP ? mk_res(0, 1, 1, 0) : mk_res(0, 8, 1, 0), STOP ? 5  : 33, STOP ? 0 : 7};

        // reset
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        check("reset_small", {s_a, s_b, s_busy, s_done, s_pass, s_err_cnt, s_fail_valid, s_fail_addr}, 0);
        reset = 1'b0;

        // table-driven full runs
        for (int i = 0; i < 5; i++) begin
            stuck = tbl[i].stuck;
            exp_q.push_back(tbl[i].res);
            load_and_start(tbl[i].vecs);
            check("busy_after_start", busy, 1);
            wait_done(1, k);
            check("done_latency", k, tbl[i].lat);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("idle_after_done", busy, 0);
            check("a_hold", a, tbl[i].vecs[tbl[i].last*5 + 3 +: 2]);
            check("b_hold", b, tbl[i].vecs[tbl[i].last*5 + 1 +: 2]);
            stuck = 1'b0;
        end

        // start and wr_en while busy: ignored, timing unchanged
        exp_q.push_back(mk_res(1, 0, 0, 0));
        load_and_start(v_ok);
        repeat (9) @(negedge clk);
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 5'b00111;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        wait_done(11, k);
        check("busy_ignore_latency", k, 33);
        @(negedge clk);
        check("busy_ignore_one_done", done, 0);
        repeat (3) @(negedge clk);
        check("busy_ignore_no_restart", busy, 0);

        // async reset during SETTLE of vector 5, then a full rerun
        load_and_start(STOP ? v_ok : v_b);
        repeat (21) @(negedge clk);                      // cycle T+22
        check("pre_reset_state", dbg_state, 2);
        check("pre_reset_b", b, 3);
        #2 reset = 1'b1;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(STOP ? mk_res(1, 0, 0, 0) : mk_res(0, 1, 1, 3));
        start_only();
        wait_done(1, k);
        check("rerun_latency", k, 33);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        // SETTLE=1, N_VEC=1: write with start, exp deliberately wrong
        @(negedge clk);
        s_wr_en = 1'b1; s_wr_addr = 3'd0; s_wr_data = 5'b10100; s_start = 1'b1;
        @(negedge clk);                                  // T+1
        s_wr_en = 1'b0; s_start = 1'b0;
        check("small_a_t1", s_a, 0);
        @(negedge clk);                                  // T+2
        check("small_ab_t2", {s_a, s_b}, 4'b1010);
        @(negedge clk);                                  // T+3
        check("small_done_t3", s_done, 0);
        @(negedge clk);                                  // T+4
        check("small_done_t4", s_done, 1);
        check("small_result", {s_pass, s_err_cnt, s_fail_valid, s_fail_addr}, mk_res(0, 1, 1, 0));
        @(negedge clk);
        check("small_done_pulse", s_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eq2_vec_seq.md
Name: eq2_vec_seq

Overview:
- Self-test sequencer for the 2-bit equality comparator datapath.
- Holds a small vector memory of {a, b, expected aeqb} entries and applies each vector to an external comparator.
- After a programmable settle time it samples the comparator output and checks it against the expected bit.
- Accumulates an error count and reports pass/fail. Sits beside the comparator as an on-chip replacement for file-driven vector testing.

Parameters:
- ADDR_W, 3, vector memory address width; depth is 2^ADDR_W.
- N_VEC, 8, number of vectors run per test; 1 <= N_VEC <= 2^ADDR_W.
- SETTLE, 2, cycles between driving a/b and sampling aeqb; SETTLE >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin test run; sampled only in IDLE.
- wr_en  in  1  vector memory write strobe; honoured only when busy=0.
- wr_addr  in  ADDR_W  vector memory write address.
- wr_data  in  5  vector {a[1:0], b[1:0], exp}; bits 4:3 a, 2:1 b, 0 exp.
- aeqb  in  1  comparator result, from the comparator under control.
- a  out  2  comparator operand a, registered.
- b  out  2  comparator operand b, registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  valid from done until next start; 1 iff err_cnt==0.
- err_cnt  out  ADDR_W+1  mismatches in current/last run.
- fail_valid  out  1  at least one mismatch captured this run.
- fail_addr  out  ADDR_W  index of first mismatching vector.

Behaviour:
- Reset: a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, fail_addr=0, idx=0, state=IDLE. Vector memory contents are not reset.
- Reset mid-run aborts immediately to the reset values; no done pulse.
- FSM states: IDLE, LOAD, SETTLE, CHECK, DONE.
- IDLE: start=1 -> LOAD. On that edge clear err_cnt, fail_valid, fail_addr, pass, and set idx=0.
- LOAD: read mem[idx] combinationally and register a, b, exp at the end of the cycle; load settle counter to SETTLE-1; -> SETTLE.
- SETTLE: count down; at 0 -> CHECK.
- CHECK:
  - Sample aeqb. If aeqb != exp, increment err_cnt. If this is the first mismatch, set fail_valid=1 and fail_addr=idx.
  - If idx==N_VEC-1 -> DONE; else idx+1 and -> LOAD.
- DONE: done=1 for this cycle only; pass=(err_cnt==0) registered and held; -> IDLE.
- Timing: start sampled at edge T gives LOAD at T+1 and first CHECK at T+SETTLE+2. Each vector takes SETTLE+2 cycles. done is high in cycle T+N_VEC*(SETTLE+2)+1; for the defaults that is T+33.
- a/b hold their last values after a run.
- err_cnt width holds N_VEC, so it never overflows.
- start while busy: ignored, no queuing.
- wr_en while busy: ignored. wr_en in IDLE writes at the edge.
- wr_en and start in the same IDLE cycle: the write completes, and the run sees the new data.

Optional Feature:
- Macro: EQ2_SEQ_STOP_ON_FAIL_EN.
- Defined: a mismatch in CHECK goes directly to DONE. err_cnt=1, fail_addr=failing idx, pass=0, and done pulses the next cycle.
- Not defined: all N_VEC vectors always run.

Decomposition:
- Package eq2_seq_pkg:
  - State encoding localparams (IDLE..DONE).
  - Vector field positions: A_MSB=4, A_LSB=3, B_MSB=2, B_LSB=1, EXP_BIT=0.
  - VEC_W=5.
- One sub-module, eq2_vec_ram: 2^ADDR_W x VEC_W, synchronous write, asynchronous read.
- FSM, settle counter, index and error logic stay in eq2_vec_seq.

Test Plan:
- Load all 8 vectors with correct exp ({00,00,1},{01,10,0},{11,11,1},...), ideal comparator, start -> done at T+33, pass=1, err_cnt=0, fail_valid=0.
- Vector 3 exp deliberately wrong -> err_cnt=1, fail_valid=1, fail_addr=3, pass=0. With EQ2_SEQ_STOP_ON_FAIL_EN, done arrives at T+4*(SETTLE+2)+1=T+17.
- Comparator output stuck at 0, vectors with 4 equal and 4 unequal pairs -> err_cnt=4, fail_addr=index of the first equal pair.
- start pulsed again mid-run and wr_en mid-run -> run timing unchanged, memory unchanged, single done pulse.
- Reset asserted asynchronously during SETTLE of vector 5 -> all outputs at reset values immediately. A new start then gives a full run with correct results.
- SETTLE=1, N_VEC=1 -> done at T+4, and a/b equal vector 0 fields from T+2.
